// File: rtl/dmem_access_unit.sv
// Load/store unit front end for the data-memory port.
// Accepts one request at a time, range-checks it, drives registered mem_*
// signals one beat per cycle and returns a valid/ready response. Misaligned
// half/word accesses are broken into byte beats and reassembled locally.
module dmem_access_unit #(
  parameter logic [31:0] MEM_BASE         = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH        = 1048576,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        mem_is_sign,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  // One past the last legal byte, kept at 33 bits so high addresses cannot wrap into range.
  localparam logic [32:0] LP_LIMIT = {1'b0, MEM_BASE} + 33'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ACCESS = 3'd2,
    S_SAMPLE = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched request
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;

  // Beat tracking and load assembly
  logic [1:0]  r_beat;
  logic [1:0]  w_beat_nxt;
  logic        w_issue;
  logic        w_hold;
  logic [31:0] r_buf;
  logic [31:0] w_buf_merged;

  // Registered outputs
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_mem_rw;
  logic        r_mem_sign;
  logic [1:0]  r_mem_size;

  // Request decode
  logic [1:0]  w_last_idx;
  logic [32:0] w_end;
  logic        w_range_err;
  logic        w_misal;
  logic        w_err;
  logic        w_last_beat;

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sgn);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign w_last_idx  = (r_size == 2'b00) ? 2'd0 : (r_size == 2'b01) ? 2'd1 : 2'd3;
  assign w_end       = {1'b0, r_addr} + {31'b0, w_last_idx} + 33'd1;
  assign w_range_err = (r_size == 2'b11) || (r_addr < MEM_BASE) || (w_end > LP_LIMIT);
  assign w_misal     = ((r_size == 2'b01) && r_addr[0]) ||
                       ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_err       = w_range_err || (w_misal && !ALLOW_MISALIGNED);
  assign w_last_beat = !w_misal || (r_beat == w_last_idx);

  assign req_ready       = (r_state == S_IDLE);
  assign resp_valid      = (r_state == S_RESP);
  assign resp_rdata      = r_rdata;
  assign resp_error      = r_error;
  assign mem_address     = r_mem_addr;
  assign mem_data_in     = r_mem_din;
  assign mem_read_write  = r_mem_rw;
  assign mem_is_sign     = r_mem_sign;
  assign mem_access_size = r_mem_size;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_err ? S_RESP : S_ACCESS;
      S_ACCESS: begin
        if (!r_write)         w_state_nxt = S_SAMPLE;
        else if (w_last_beat) w_state_nxt = S_RESP;
        else                  w_state_nxt = S_ACCESS;
      end
      S_SAMPLE: w_state_nxt = w_last_beat ? S_RESP : S_ACCESS;
      S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Beat sequencing: decide when a new beat is launched onto the memory bus
  always_comb begin
    w_issue    = 1'b0;
    w_hold     = 1'b0;
    w_beat_nxt = r_beat;
    case (r_state)
      S_DECODE: begin
        if (!w_err) begin
          w_issue    = 1'b1;
          w_beat_nxt = 2'd0;
        end
      end
      S_ACCESS: begin
        if (!r_write) begin
          w_hold = 1'b1;
        end else if (!w_last_beat) begin
          w_issue    = 1'b1;
          w_beat_nxt = r_beat + 2'd1;
        end
      end
      S_SAMPLE: begin
        if (!w_last_beat) begin
          w_issue    = 1'b1;
          w_beat_nxt = r_beat + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Capture the request on acceptance
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && req_valid) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
      r_sign  <= req_sign;
    end
  end

  // Memory bus registers: load a beat, hold through a load sample, else idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_beat     <= 2'd0;
      r_mem_addr <= MEM_BASE;
      r_mem_din  <= 32'd0;
      r_mem_rw   <= 1'b0;
      r_mem_sign <= 1'b0;
      r_mem_size <= 2'b10;
    end else if (w_issue) begin
      r_beat     <= w_beat_nxt;
      r_mem_addr <= r_addr + {30'b0, w_beat_nxt};
      r_mem_rw   <= r_write;
      if (w_misal) begin
        r_mem_size <= 2'b00;
        r_mem_sign <= 1'b0;
        r_mem_din  <= r_write ? {24'b0, r_wdata[{w_beat_nxt, 3'b000} +: 8]} : 32'd0;
      end else begin
        r_mem_size <= r_size;
        r_mem_sign <= r_sign;
        r_mem_din  <= r_write ? r_wdata : 32'd0;
      end
    end else if (!w_hold) begin
      r_mem_addr <= MEM_BASE;
      r_mem_din  <= 32'd0;
      r_mem_rw   <= 1'b0;
      r_mem_sign <= 1'b0;
      r_mem_size <= 2'b10;
    end
  end

  // Merge the byte returned for the current beat into the assembly buffer
  always_comb begin
    w_buf_merged = r_buf;
    w_buf_merged[{r_beat, 3'b000} +: 8] = mem_data_out[7:0];
  end

  // Assembly buffer for split loads
  always_ff @(posedge clock) begin
    if (r_state == S_SAMPLE) r_buf <= w_buf_merged;
  end

  // Response data and error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_DECODE: begin
          r_rdata <= 32'd0;
          r_error <= w_err;
        end
        S_SAMPLE: begin
          if (!w_misal)         r_rdata <= mem_data_out;
          else if (w_last_beat) r_rdata <= f_extend(w_buf_merged, r_size, r_sign);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: byte-addressed memory behind the port, a
// byte-level reference model, directed cases and a randomized sweep.
module tb_dmem_access_unit;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1048576;
  localparam logic [31:0] LIMIT = 32'h0110_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic        mem_is_sign;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out = 32'd0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
  } wr_t;
  wr_t wr_q[$];

  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] mdl_mem [logic [31:0]];

  dmem_access_unit #(
    .MEM_BASE(BASE),
    .MEM_DEPTH(DEPTH),
    .ALLOW_MISALIGNED(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_size(req_size),
    .req_sign(req_sign),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write),
    .mem_is_sign(mem_is_sign),
    .mem_access_size(mem_access_size),
    .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] env_byte(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] mdl_byte(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 8'h00;
  endfunction

  // Data memory: writes land on the rising edge, reads update mid-cycle
  always @(posedge clock) begin
    if (reset === 1'b1 && mem_read_write === 1'b1) begin
      for (int k = 0; k < nbytes(mem_access_size); k++)
        env_mem[mem_address + 32'(k)] = mem_data_in[8*k +: 8];
      wr_q.push_back('{a: mem_address, s: mem_access_size, d: mem_data_in});
    end
  end

  always @(negedge clock) begin
    logic [31:0] v;
    int n;
    n = nbytes(mem_access_size);
    v = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = env_byte(mem_address + 32'(k));
    if (mem_is_sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    mem_data_out <= v;
  end

  // Reference load: little-endian bytes, extended from the top bit of the access
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sgn);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mdl_byte(a + 32'(k))) << (8*k));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic sgn, input int hold);
    int n, exp_lat, exp_wr, lat;
    bit err, mis, seen;
    logic [31:0] exp_rd, ea, ed;
    logic [1:0]  es;
    n   = nbytes(size);
    err = (size == 2'b11) || (addr < BASE) ||
          (longint'(addr) + longint'(n) > longint'(BASE) + longint'(DEPTH));
    mis = (size != 2'b11) && ((addr % n) != 0);
    if (err)     exp_lat = 1;
    else if (wr) exp_lat = mis ? n + 1 : 2;
    else         exp_lat = mis ? 2*n + 1 : 3;
    exp_wr = (!err && wr) ? (mis ? n : 1) : 0;
    exp_rd = (!err && !wr) ? model_load(addr, size, sgn) : 32'd0;
    if (!err && wr)
      for (int k = 0; k < n; k++) mdl_mem[addr + 32'(k)] = wdata[8*k +: 8];

    wr_q.delete();
    resp_ready = (hold == 0);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sign  = sgn;
    @(posedge clock); #1;
    req_valid = 1'b0;

    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clock); #1;
        lat++;
      end
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_error", 32'(resp_error), 32'(err));
    chk("write_beats", 32'(wr_q.size()), 32'(exp_wr));
    for (int k = 0; k < wr_q.size() && k < exp_wr; k++) begin
      ea = addr + (mis ? 32'(k) : 32'd0);
      es = mis ? 2'b00 : size;
      ed = mis ? {24'b0, wdata[8*k +: 8]} : wdata;
      chk("wr_addr", wr_q[k].a, ea);
      chk("wr_size", 32'(wr_q[k].s), 32'(es));
      chk("wr_data", wr_q[k].d, ed);
    end

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
      @(posedge clock); #1;
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_mem_rw", 32'(mem_read_write), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rw"}, 32'(mem_read_write), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
    chk({tag, "_mem_addr"}, mem_address, BASE);
    chk({tag, "_mem_din"}, mem_data_in, 32'd0);
    chk({tag, "_mem_sign"}, 32'(mem_is_sign), 32'd0);
    chk({tag, "_mem_size"}, 32'(mem_access_size), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int sel;

    // Reset values
    #12;
    chk_idle_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Aligned word store then load
    xact(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
    xact(1'b0, 32'h0100_0010, 32'h0, 2'b10, 1'b0, 0);

    // Byte sign/zero extension and a signed halfword
    xact(1'b1, 32'h0100_0003, 32'h0000_0080, 2'b00, 1'b0, 0);
    xact(1'b0, 32'h0100_0003, 32'h0, 2'b00, 1'b1, 0);
    xact(1'b0, 32'h0100_0003, 32'h0, 2'b00, 1'b0, 1);
    xact(1'b1, 32'h0100_0002, 32'h0000_0080, 2'b00, 1'b0, 0);
    xact(1'b1, 32'h0100_0003, 32'h0000_007F, 2'b00, 1'b0, 0);
    xact(1'b0, 32'h0100_0002, 32'h0, 2'b01, 1'b1, 0);

    // Misaligned word store/load, misaligned signed half
    xact(1'b1, 32'h0100_0005, 32'h1122_3344, 2'b10, 1'b0, 1);
    xact(1'b0, 32'h0100_0005, 32'h0, 2'b10, 1'b0, 0);
    xact(1'b1, 32'h0100_0021, 32'h0000_9A55, 2'b01, 1'b0, 0);
    xact(1'b0, 32'h0100_0021, 32'h0, 2'b01, 1'b1, 2);

    // Range and size errors, plus the last legal word
    xact(1'b0, 32'h00FF_FFFF, 32'h0, 2'b00, 1'b0, 0);
    xact(1'b0, LIMIT - 32'd2, 32'h0, 2'b10, 1'b0, 0);
    xact(1'b1, LIMIT - 32'd2, 32'hCAFE_F00D, 2'b10, 1'b0, 0);
    xact(1'b1, 32'h0100_0040, 32'h1234_5678, 2'b11, 1'b0, 0);
    xact(1'b1, 32'hFFFF_FFFE, 32'h1234_5678, 2'b01, 1'b0, 0);
    xact(1'b1, LIMIT - 32'd4, 32'hA5A5_5A5A, 2'b10, 1'b0, 0);
    xact(1'b0, LIMIT - 32'd4, 32'h0, 2'b10, 1'b0, 0);

    // Long back-pressure on the response
    xact(1'b0, 32'h0100_0010, 32'h0, 2'b10, 1'b0, 5);

    // Reset during the second beat of a misaligned store
    wr_q.delete();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0100_0005;
    req_wdata = 32'hA1B2_C3D4;
    req_size  = 2'b10;
    req_sign  = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rst_beat0_rw", 32'(mem_read_write), 32'd1);
    @(posedge clock); #1;
    chk("rst_beat1_rw", 32'(mem_read_write), 32'd1);
    chk("rst_beat1_addr", mem_address, 32'h0100_0006);
    reset = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    // Only the first byte beat reached memory before reset.
    mdl_mem[32'h0100_0005] = 8'hD4;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("rst_writes", 32'(wr_q.size()), 32'd1);
    xact(1'b0, 32'h0100_0004, 32'h0, 2'b10, 1'b0, 0);
    xact(1'b0, 32'h0100_0005, 32'h0, 2'b10, 1'b0, 0);

    // Randomized sweep
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = BASE - 32'($urandom_range(1, 4));
        1:       a = LIMIT - 32'($urandom_range(0, 6));
        2:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: a = BASE + 32'($urandom_range(0, 23));
      endcase
      xact(1'($urandom_range(0, 1)), a, $urandom,
           ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the data-memory port: the CPU's load/store unit.
- Accepts one load/store request at a time from the memory stage and checks the address range.
- Drives the data-memory interface with byte address, write data, read_write, is_sign and access_size, then returns load data with a valid/ready response.
- Misaligned halfword/word accesses are split into sequential byte beats, with assembly and sign extension done locally.

Parameters:
MEM_BASE, 32'h01000000, byte address of data-memory location 0
MEM_DEPTH, 1048576, data-memory size in bytes
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into byte beats; 0 = flag them as errors

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data (low bytes used for byte/half)
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_sign  in  1  1 = sign-extend load, 0 = zero-extend
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  load result, extended to 32 bits (0 for stores)
resp_error  out  1  illegal size, out-of-range address, or disallowed misalignment
mem_address  out  32  byte address to data memory
mem_data_in  out  32  write data to data memory
mem_read_write  out  1  1 = write on the next rising edge, 0 = read
mem_is_sign  out  1  sign control to data memory
mem_access_size  out  2  size to data memory
mem_data_out  in  32  read data from data memory

Behaviour:
- Reset is asynchronous and active-low:
  - state goes to IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0.
  - mem_address=MEM_BASE, mem_data_in=0, mem_read_write=0, mem_is_sign=0, mem_access_size=2'b10.
  - Reset asserted mid-operation abandons the transaction, drops mem_read_write immediately and returns no response.
- All mem_* outputs are registered. mem_read_write is 1 only during a WRITE beat cycle.
- IDLE (req_ready=1): on req_valid, latch the request. Let N = bytes for the size (1/2/4).
  - size 11, addr < MEM_BASE, or addr+N > MEM_BASE+MEM_DEPTH -> RESP, error=1, no memory activity.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) and ALLOW_MISALIGNED=0 -> RESP, error=1.
  - Aligned -> one beat: mem_access_size=req_size, mem_is_sign=req_sign.
  - Misaligned and allowed -> N byte beats: mem_access_size=00, mem_is_sign=0; beat k uses address addr+k.
- ACCESS, one cycle per beat:
  - Store: mem_read_write=1; mem_data_in = req_wdata for an aligned beat, or {24'b0, req_wdata[8k+7:8k]} for byte beat k. Advance to the next beat, or to RESP after the last.
  - Load: mem_read_write=0; go to SAMPLE with all mem_* held stable.
- SAMPLE (load only): capture mem_data_out.
  - Aligned: resp_rdata = mem_data_out.
  - Byte beats: byte k = mem_data_out[7:0] goes to buffer bits [8k+7:8k].
  - After the last beat, extend from bit 8N-1 per req_sign, then go to RESP. Otherwise return to ACCESS with beat k+1.
- RESP: resp_valid=1 with stable resp_rdata/resp_error until resp_ready. On handshake go to IDLE; mem_* return to their idle values.
- req_ready=1 only in IDLE. Requests in other states are not accepted. No back-to-back acceptance in the RESP handshake cycle.
- Latency from the acceptance edge to resp_valid:
  - aligned load 3 cycles; aligned store 2.
  - misaligned load 2N+1; misaligned store N+1.
  - error 1.
- Arithmetic: address adds are 32-bit unsigned. The range check uses 33-bit sums so that addr near 0xFFFFFFFF does not wrap into range.
- resp_ready held high in the same cycle resp_valid rises: completes the handshake on that edge.

Test Plan:
- Aligned word store 0xDEADBEEF to 0x01000010, then load word -> one write cycle with mem_access_size=10; load returns resp_rdata=0xDEADBEEF, error=0, latency 3.
- Byte 0x80 at 0x01000003; load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080; half signed at 0x01000002 over bytes 0x80,0x7F -> 0x00007F80.
- Misaligned word store 0x11223344 to 0x01000005 -> four byte writes 0x44,0x33,0x22,0x11 at 0x01000005..8; word load back -> 0x11223344 after 9 cycles.
- Out of range: load at 0x00FFFFFF, word at MEM_BASE+MEM_DEPTH-2, size 11, addr 0xFFFFFFFE -> resp_error=1, mem_read_write never 1.
- resp_ready held low 5 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout; a new req_valid is ignored until after the handshake.
- Reset asserted during beat 2 of a misaligned store -> mem_read_write=0 immediately; outputs at reset values; no response; the next request completes normally.
